// File: rtl/gemm_job_arbiter.sv
// gemm_job_arbiter: round-robin owner selection for one shared gemm_top engine.
// It grants a single requester, pulses the engine start, and waits for done
// under a watchdog. It then returns a one-cycle completion (with error flag)
// to the owner. All outputs come straight from flops.
module gemm_job_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int SEL_W          = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic               iclk,
    input  logic               irst,
    input  logic [NUM_REQ-1:0] ireq_valid,
    output logic [NUM_REQ-1:0] ogrant,
    output logic [SEL_W-1:0]   osel,
    output logic               ogemm_start,
    input  logic               igemm_busy,
    input  logic               igemm_done,
    output logic               ogemm_abort,
    output logic [NUM_REQ-1:0] ocomplete,
    output logic               oerr,
    output logic [CNT_W-1:0]   ojob_count,
    output logic               obusy
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t             r_state, w_next;
    logic [NUM_REQ-1:0] r_grant, w_grant;
    logic [SEL_W-1:0]   r_sel, w_sel;
    logic [SEL_W-1:0]   r_ptr, w_ptr;
    logic [WD_W-1:0]    r_wd, w_wd;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [NUM_REQ-1:0] r_cpl, w_cpl;
    logic               r_start, w_start;
    logic               r_abort, w_abort;
    logic               r_err, w_err;
    logic               r_busy, w_busy;
    logic [SEL_W-1:0]   w_pick;
    logic               w_any;
    logic               w_wd_last;

    // Engine busy is informational only; nothing in the schedule depends on it.
    logic w_unused_busy;
    assign w_unused_busy = igemm_busy;

    // Requester index 'off' positions after 'base', wrapping at NUM_REQ.
    function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] base, input int off);
        int t;
        t = (int'(base) + off) % NUM_REQ;
        return SEL_W'(t);
    endfunction

    assign w_any     = |ireq_valid;
    assign w_wd_last = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

    // Round-robin pick: first pending requester after the last owner. The
    // loop runs from farthest to nearest so the nearest set bit wins.
    always_comb begin
        w_pick = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (ireq_valid[rr_idx(r_ptr, i)]) w_pick = rr_idx(r_ptr, i);
        end
    end

    // State register; synchronous reset drops any in-flight job silently.
    always_ff @(posedge iclk) begin
        if (irst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic; done beats the watchdog when both land together.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT:   if (igemm_done || w_wd_last) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output/datapath next values, registered below so every output is a flop.
    always_comb begin
        w_grant = r_grant;
        w_sel   = r_sel;
        w_ptr   = r_ptr;
        w_wd    = r_wd;
        w_cnt   = r_cnt;
        w_cpl   = '0;
        w_start = 1'b0;
        w_abort = 1'b0;
        w_err   = 1'b0;
        w_busy  = (w_next != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant         = '0;
                    w_grant[w_pick] = 1'b1;
                    w_sel           = w_pick;
                    w_start         = 1'b1;
                end
            end
            S_LAUNCH: w_wd = '0;
            S_WAIT: begin
                w_wd = r_wd + 1'b1;
                if (igemm_done) begin
                    w_cpl = r_grant;
                    w_cnt = r_cnt + 1'b1;
                end else if (w_wd_last) begin
                    w_cpl   = r_grant;
                    w_err   = 1'b1;
                    w_abort = 1'b1;
                end
            end
            S_RESP: begin
                // osel is left as-is; ogrant=0 already marks the engine free.
                w_ptr   = r_sel;
                w_grant = '0;
            end
            default: ;
        endcase
    end

    // Output and bookkeeping registers.
    always_ff @(posedge iclk) begin
        if (irst) begin
            r_grant <= '0;
            r_sel   <= '0;
            r_ptr   <= SEL_W'(NUM_REQ - 1);
            r_wd    <= '0;
            r_cnt   <= '0;
            r_cpl   <= '0;
            r_start <= 1'b0;
            r_abort <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_grant <= w_grant;
            r_sel   <= w_sel;
            r_ptr   <= w_ptr;
            r_wd    <= w_wd;
            r_cnt   <= w_cnt;
            r_cpl   <= w_cpl;
            r_start <= w_start;
            r_abort <= w_abort;
            r_err   <= w_err;
            r_busy  <= w_busy;
        end
    end

    assign ogrant      = r_grant;
    assign osel        = r_sel;
    assign ogemm_start = r_start;
    assign ogemm_abort = r_abort;
    assign ocomplete   = r_cpl;
    assign oerr        = r_err;
    assign ojob_count  = r_cnt;
    assign obusy       = r_busy;
endmodule
